// File: rtl/pipe_stage_hs.sv
// -----------------------------------------------------------------------------
// pipe_stage_hs
//
// Parametrised front-end pipeline register that carries {addr, inst,
// compressed flag} between two stages using a valid/ready handshake. It
// replaces the fixed-width preif/if register, which relied on a global stall.
//
// The stage holds two slots:
//   - main slot M drives the outputs
//   - skid slot S catches the one entry that may arrive while M is stalled
// Because of S, in_ready_o can be a register output with no combinational
// path from out_ready_i, and the stage still moves one entry per cycle.
//
// An entry accepted at a rising edge is visible on the outputs just after
// that edge. There is no input-to-output bypass.
//
// Optional feature (compile-time macro PIPE_DROP_ADDR_EN):
//   When the macro is defined, an accepted entry whose address equals
//   DROP_ADDR is consumed but never stored. This replaces the hard-wired
//   "reset address minus 4" bubble squash of the old register.
//   When the macro is undefined, every accepted entry is stored.
//
// Parameters:
//   ADDR_W     width of the address field
//   INST_W     width of the instruction field
//   NOP_INST   inst value loaded on reset/flush (addi x0,x0,0)
//   RST_ADDR   addr value loaded on reset/flush
//   DROP_ADDR  sentinel address that is discarded when PIPE_DROP_ADDR_EN is set
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   rst          synchronous, active-high reset
//   flush_i      discard all held entries at the next edge
//   in_valid_i   upstream entry valid
//   in_ready_o   stage can accept (register output)
//   in_addr_i    upstream address
//   in_inst_i    upstream instruction
//   in_cmp_i     upstream compressed-instruction flag
//   out_valid_o  downstream entry valid
//   out_ready_i  downstream accepts
//   out_addr_o   held address
//   out_inst_o   held instruction
//   out_cmp_o    held compressed flag
//   occ_o        number of entries held (0..2)
// -----------------------------------------------------------------------------
module pipe_stage_hs #(
    parameter int unsigned         ADDR_W    = 32,
    parameter int unsigned         INST_W    = 32,
    parameter logic [INST_W-1:0]   NOP_INST  = INST_W'(32'h0000_0013),
    parameter logic [ADDR_W-1:0]   RST_ADDR  = '0,
    parameter logic [ADDR_W-1:0]   DROP_ADDR = ADDR_W'(32'h7FFF_FFFC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,

    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [ADDR_W-1:0] in_addr_i,
    input  logic [INST_W-1:0] in_inst_i,
    input  logic              in_cmp_i,

    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic [INST_W-1:0] out_inst_o,
    output logic              out_cmp_o,

    output logic [1:0]        occ_o
);

    // -------------------------------------------------------------------------
    // Types
    // -------------------------------------------------------------------------
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [INST_W-1:0] inst;
        logic              cmp;
    } entry_t;

    // Source selection for the main slot data register.
    typedef enum logic [1:0] {
        M_HOLD,     // keep current contents
        M_FROM_IN,  // load the accepted input entry
        M_FROM_S,   // promote the skid slot
        M_CLEAR     // load reset values (flush)
    } m_src_e;

    localparam entry_t RST_ENTRY = '{addr: RST_ADDR, inst: NOP_INST, cmp: 1'b0};

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic   m_valid;
    logic   s_valid;
    entry_t m_data;
    entry_t s_data;

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    entry_t in_data;
    logic   acc;      // upstream transfer happens this cycle
    logic   pop;      // downstream transfer happens this cycle
    logic   is_drop;  // accepted entry is the sentinel and must not be stored
    logic   store;    // accepted entry is written into a slot

    assign in_data = '{addr: in_addr_i, inst: in_inst_i, cmp: in_cmp_i};

    // S can only be full while M is full, so S empty is exactly "room for one
    // more". It is a straight flop output and does not depend on out_ready_i.
    assign in_ready_o = ~s_valid;

    assign acc = in_valid_i & in_ready_o;
    assign pop = m_valid & out_ready_i;

`ifdef PIPE_DROP_ADDR_EN
    assign is_drop = (in_addr_i == DROP_ADDR);
`else
    assign is_drop = 1'b0;

    // The sentinel only matters when the drop feature is built in.
    logic unused_drop_addr;
    assign unused_drop_addr = ^DROP_ADDR;
`endif

    assign store = acc & ~is_drop;

    // -------------------------------------------------------------------------
    // Next-state decode (reset is applied in the register process)
    // -------------------------------------------------------------------------
    logic   m_valid_d;
    logic   s_valid_d;
    m_src_e m_src;
    logic   s_load;   // write the input entry into S
    logic   s_clear;  // return S data to reset values

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path can
        // leave it unassigned; a missing default here would infer a latch.
        m_valid_d = m_valid;
        s_valid_d = s_valid;
        m_src     = M_HOLD;
        s_load    = 1'b0;
        s_clear   = 1'b0;

        if (flush_i) begin
            // Flush outranks everything else, including an entry accepted
            // in the same cycle: that entry is simply thrown away.
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
            m_src     = M_CLEAR;
            s_clear   = 1'b1;
        end else if (s_valid) begin
            // Both slots full. in_ready_o is low, so nothing can be accepted;
            // the only possible move is promoting S once M drains.
            if (pop) begin
                m_src     = M_FROM_S;
                m_valid_d = 1'b1;
                s_valid_d = 1'b0;
            end
        end else if (store) begin
            if (!m_valid || pop) begin
                // M is empty or is emptying this cycle: refill it directly.
                m_src     = M_FROM_IN;
                m_valid_d = 1'b1;
            end else begin
                // M is full and stalled: park the entry in the skid slot.
                s_load    = 1'b1;
                s_valid_d = 1'b1;
            end
        end else if (pop) begin
            // Drained with nothing to replace it. The data stays as it was,
            // so only the valid bit falls.
            m_valid_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            // NOTE: the data slots are reset too, not only the valid bits,
            // because the outputs are architecturally visible as a NOP at
            // RST_ADDR straight after reset.
            m_data  <= RST_ENTRY;
            s_data  <= RST_ENTRY;
        end else begin
            m_valid <= m_valid_d;
            s_valid <= s_valid_d;

            case (m_src)
                M_FROM_IN: m_data <= in_data;
                M_FROM_S:  m_data <= s_data;
                M_CLEAR:   m_data <= RST_ENTRY;
                default:   m_data <= m_data;
            endcase

            if (s_clear) begin
                s_data <= RST_ENTRY;
            end else if (s_load) begin
                s_data <= in_data;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign out_valid_o = m_valid;
    assign out_addr_o  = m_data.addr;
    assign out_inst_o  = m_data.inst;
    assign out_cmp_o   = m_data.cmp;
    assign occ_o       = {1'b0, m_valid} + {1'b0, s_valid};

endmodule

// File: tb/tb_pipe_stage_hs.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_hs
//
// Self-checking bench for pipe_stage_hs with default parameters.
//   1. Directed table: reset, streaming, skid fill, pop+accept, flush.
//   2. Hand-written sentinel-address sequence. The expected values follow
//      PIPE_DROP_ADDR_EN, so the bench must be built with the same macro
//      setting as the RTL.
//   3. Random traffic checked against a queue model of a two-entry FIFO.
// -----------------------------------------------------------------------------
module tb_pipe_stage_hs;

    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [31:0] DROP_ADDR = 32'h7FFF_FFFC;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_addr_i;
    logic [31:0] in_inst_i;
    logic        in_cmp_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_addr_o;
    logic [31:0] out_inst_o;
    logic        out_cmp_o;
    logic [1:0]  occ_o;

    pipe_stage_hs dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_addr_i   (in_addr_i),
        .in_inst_i   (in_inst_i),
        .in_cmp_i    (in_cmp_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_addr_o  (out_addr_o),
        .out_inst_o  (out_inst_o),
        .out_cmp_o   (out_cmp_o),
        .occ_o       (occ_o)
    );

    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Observation record and checker
    // -------------------------------------------------------------------------
    typedef struct packed {
        logic        valid;
        logic        ready;
        logic [1:0]  occ;
        logic [31:0] addr;
        logic [31:0] inst;
        logic        cmp;
    } obs_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
        logic        cmp;
    } entry_t;

    int checks   = 0;
    int failures = 0;

    function automatic obs_t dut_obs();
        obs_t o;
        o.valid = out_valid_o;
        o.ready = in_ready_o;
        o.occ   = occ_o;
        o.addr  = out_addr_o;
        o.inst  = out_inst_o;
        o.cmp   = out_cmp_o;
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got v=%b r=%b occ=%0d addr=%h inst=%h cmp=%b, want v=%b r=%b occ=%0d addr=%h inst=%h cmp=%b",
                     name, act.valid, act.ready, act.occ, act.addr, act.inst, act.cmp,
                     exp.valid, exp.ready, exp.occ, exp.addr, exp.inst, exp.cmp);
        end
    endtask

    // Compare only valid and occupancy, for cases where the held data is not
    // the point of the check.
    task automatic check_vo(input string name, input logic v, input logic [1:0] occ,
                            input logic exp_v, input logic [1:0] exp_occ);
        checks++;
        if (v !== exp_v || occ !== exp_occ) begin
            failures++;
            $display("FAIL %s: got v=%b occ=%0d, want v=%b occ=%0d",
                     name, v, occ, exp_v, exp_occ);
        end
    endtask

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive an entry whose inst and cmp are derived from its address.
    task automatic drive(input logic r, input logic f, input logic v,
                         input logic [31:0] a, input logic ordy);
        rst         = r;
        flush_i     = f;
        in_valid_i  = v;
        in_addr_i   = a;
        in_inst_i   = ~a;
        in_cmp_i    = a[2];
        out_ready_i = ordy;
    endtask

    // -------------------------------------------------------------------------
    // Directed vector table
    // -------------------------------------------------------------------------
    typedef struct {
        string       name;
        logic        rst;
        logic        flush;
        logic        in_valid;
        logic [31:0] addr;
        logic        out_ready;
        logic        exp_valid;
        logic        exp_ready;
        logic [1:0]  exp_occ;
        logic [31:0] exp_addr;
        logic        exp_nop;   // 1: outputs show the reset NOP at exp_addr
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string n, input logic r, input logic f, input logic v,
                       input logic [31:0] a, input logic ordy,
                       input logic ev, input logic er, input logic [1:0] eo,
                       input logic [31:0] ea, input logic enop);
        vec_t t;
        t.name = n;  t.rst = r; t.flush = f; t.in_valid = v; t.addr = a;
        t.out_ready = ordy; t.exp_valid = ev; t.exp_ready = er; t.exp_occ = eo;
        t.exp_addr = ea; t.exp_nop = enop;
        vecs.push_back(t);
    endtask

    function automatic obs_t vec_exp(input vec_t t);
        obs_t o;
        o.valid = t.exp_valid;
        o.ready = t.exp_ready;
        o.occ   = t.exp_occ;
        o.addr  = t.exp_addr;
        o.inst  = t.exp_nop ? NOP : ~t.exp_addr;
        o.cmp   = t.exp_nop ? 1'b0 : t.exp_addr[2];
        return o;
    endfunction

    // -------------------------------------------------------------------------
    // Reference model: an ordered queue holding at most two entries
    // -------------------------------------------------------------------------
    entry_t model_q[$];
    entry_t model_held;   // what the outputs show (last front entry)

    // -------------------------------------------------------------------------
    // Test sequence
    // -------------------------------------------------------------------------
    initial begin
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        //   name            rst flush  iv  addr           ordy  ev  er  occ  exp_addr     nop
        add("reset0",        1, 0,     0, 32'h0,         0,    0,  1,  0,   32'h0,        1);
        add("reset1",        1, 0,     0, 32'h0,         0,    0,  1,  0,   32'h0,        1);
        add("reset_release", 0, 0,     0, 32'h0,         1,    0,  1,  0,   32'h0,        1);
        add("stream0",       0, 0,     1, 32'h8000_0000, 1,    1,  1,  1,   32'h8000_0000, 0);
        add("stream1",       0, 0,     1, 32'h8000_0004, 1,    1,  1,  1,   32'h8000_0004, 0);
        add("stream2",       0, 0,     1, 32'h8000_0008, 1,    1,  1,  1,   32'h8000_0008, 0);
        add("stall_hold",    0, 0,     0, 32'h0,         0,    1,  1,  1,   32'h8000_0008, 0);
        add("skid_fill",     0, 0,     1, 32'h8000_0010, 0,    1,  0,  2,   32'h8000_0008, 0);
        add("skid_blocked",  0, 0,     1, 32'h8000_0014, 0,    1,  0,  2,   32'h8000_0008, 0);
        add("skid_drain",    0, 0,     0, 32'h0,         1,    1,  1,  1,   32'h8000_0010, 0);
        add("pop_and_acc",   0, 0,     1, 32'h8000_0020, 1,    1,  1,  1,   32'h8000_0020, 0);
        add("refill_skid",   0, 0,     1, 32'h8000_0030, 0,    1,  0,  2,   32'h8000_0020, 0);
        add("flush_full",    0, 1,     1, 32'h8000_0040, 0,    0,  1,  0,   32'h0,        1);
        add("after_flush",   0, 0,     0, 32'h0,         1,    0,  1,  0,   32'h0,        1);
        add("single_load",   0, 0,     1, 32'h8000_0050, 0,    1,  1,  1,   32'h8000_0050, 0);
        add("drain_holds",   0, 0,     0, 32'h0,         1,    0,  1,  0,   32'h8000_0050, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].flush, vecs[i].in_valid, vecs[i].addr, vecs[i].out_ready);
            step();
            check(vecs[i].name, dut_obs(), vec_exp(vecs[i]));
        end

        // ---------------------------------------------------------------------
        // Sentinel address: emerges only when the drop feature is off
        // ---------------------------------------------------------------------
        drive(1'b0, 1'b0, 1'b1, DROP_ADDR, 1'b1);
        step();
`ifdef PIPE_DROP_ADDR_EN
        check_vo("drop_sentinel", out_valid_o, occ_o, 1'b0, 2'd0);
`else
        check("keep_sentinel", dut_obs(),
              '{valid: 1'b1, ready: 1'b1, occ: 2'd1, addr: DROP_ADDR, inst: ~DROP_ADDR, cmp: DROP_ADDR[2]});
`endif
        drive(1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b1);
        step();
        check("after_sentinel", dut_obs(),
              '{valid: 1'b1, ready: 1'b1, occ: 2'd1, addr: 32'h8000_0000, inst: ~32'h8000_0000, cmp: 1'b0});

        // Sentinel arriving while M is stalled must not occupy the skid slot.
        drive(1'b0, 1'b0, 1'b1, DROP_ADDR, 1'b0);
        step();
`ifdef PIPE_DROP_ADDR_EN
        check_vo("drop_while_stalled", out_valid_o, occ_o, 1'b1, 2'd1);
`else
        check_vo("keep_while_stalled", out_valid_o, occ_o, 1'b1, 2'd2);
`endif

        // ---------------------------------------------------------------------
        // Random traffic against the queue model
        // ---------------------------------------------------------------------
        model_q.delete();
        model_held = '{addr: 32'h0, inst: NOP, cmp: 1'b0};
        for (int cyc = 0; cyc < 3000; cyc++) begin
            entry_t e;
            logic   m_ready, m_acc, m_pop, m_drop;
            obs_t   exp;

            rst         = (cyc < 2) || ($urandom_range(0, 299) == 0);
            flush_i     = ($urandom_range(0, 39) == 0);
            in_valid_i  = ($urandom_range(0, 9) < 7);
            out_ready_i = ($urandom_range(0, 9) < 6);
            e.addr      = ($urandom_range(0, 7) == 0) ? DROP_ADDR : $urandom();
            e.inst      = $urandom();
            e.cmp       = 1'($urandom_range(0, 1));
            in_addr_i   = e.addr;
            in_inst_i   = e.inst;
            in_cmp_i    = e.cmp;

            m_ready = (model_q.size() < 2);
            m_acc   = in_valid_i && m_ready;
            m_pop   = (model_q.size() > 0) && out_ready_i;
`ifdef PIPE_DROP_ADDR_EN
            m_drop  = (e.addr == DROP_ADDR);
`else
            m_drop  = 1'b0;
`endif
            step();

            if (rst || flush_i) begin
                model_q.delete();
                model_held = '{addr: 32'h0, inst: NOP, cmp: 1'b0};
            end else begin
                if (m_pop) void'(model_q.pop_front());
                if (m_acc && !m_drop) model_q.push_back(e);
                if (model_q.size() > 0) model_held = model_q[0];
            end

            exp.valid = (model_q.size() > 0);
            exp.ready = (model_q.size() < 2);
            exp.occ   = 2'(model_q.size());
            exp.addr  = model_held.addr;
            exp.inst  = model_held.inst;
            exp.cmp   = model_held.cmp;
            check("random", dut_obs(), exp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_hs.md
Name: pipe_stage_hs

Overview:
- Parametrised successor to the fixed-width preif/if pipeline register.
- Carries {addr, inst, compressed flag} between two front-end stages using a valid/ready handshake instead of a global stall.
- Has a 2-entry skid buffer, so the upstream stage sees a registered ready and still gets full throughput.
- Supports flush, and optionally discards designated sentinel-address entries.

Parameters:
- ADDR_W, 32, width of instruction address field
- INST_W, 32, width of instruction data field
- NOP_INST, 32'h0000_0013, reset/flush value of the inst field (addi x0,x0,0)
- RST_ADDR, 0, reset/flush value of the addr field
- DROP_ADDR, 32'h7FFF_FFFC, sentinel address discarded when PIPE_DROP_ADDR_EN is defined

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- flush_i  in  1  discard all held entries at next edge
- in_valid_i  in  1  upstream entry valid
- in_ready_o  out  1  stage can accept (registered)
- in_addr_i  in  ADDR_W  upstream address
- in_inst_i  in  INST_W  upstream instruction
- in_cmp_i  in  1  upstream compressed-instruction flag
- out_valid_o  out  1  downstream entry valid
- out_ready_i  in  1  downstream accepts
- out_addr_o  out  ADDR_W  held address
- out_inst_o  out  INST_W  held instruction
- out_cmp_o  out  1  held compressed flag
- occ_o  out  2  entries held (0..2)

Behaviour:
- Storage: main slot M drives the outputs; skid slot S. Each slot has a valid bit plus {addr, inst, cmp}.
- Handshake definitions:
  - acc = in_valid_i & in_ready_o
  - pop = out_valid_o & out_ready_i
- in_ready_o = !S.valid. It is a register output, with no combinational path from out_ready_i.
- Output signals:
  - out_valid_o = M.valid
  - out_addr_o, out_inst_o, out_cmp_o come directly from M
  - occ_o = M.valid + S.valid
- Latency: an entry accepted at edge N is visible on the outputs after edge N. There is no bypass.
- Next-state rules, applied at each edge in priority order:
  - rst: M.valid=0, S.valid=0, both data slots = {RST_ADDR, NOP_INST, 0}. After reset: in_ready_o=1, out_valid_o=0, occ_o=0.
  - flush_i (and not rst):
    - both valid bits cleared, data slots loaded with reset values
    - an entry accepted in the same cycle is discarded
    - in_ready_o=1 in the following cycle
  - S.valid=1: if pop then M<=S and S.valid<=0; otherwise hold. No acc is possible in this state.
  - S.valid=0 and acc:
    - if !M.valid or pop: M<=input
    - otherwise S<=input (M is full and stalled)
  - S.valid=0, no acc, pop: M.valid<=0. The data field holds its last value.
- Stability: while out_valid_o=1 and out_ready_i=0, all out_* signals must hold constant.
- Ordering: entries leave in acceptance order. None is lost or duplicated except by flush/drop.
- Throughput: one entry per cycle when out_ready_i is held at 1.
- Register enables are derived only from the rules above. Data changes with no valid bit must never produce a pop.

Optional Feature:
- Macro PIPE_DROP_ADDR_EN.
- Defined:
  - an accepted entry with in_addr_i == DROP_ADDR is consumed (acc true, in_ready_o unaffected) but not stored
  - occ_o is unchanged by that entry
  - this replaces the hard-wired "PC_RESET_ADDR-4" bubble squash
- Undefined: DROP_ADDR is ignored and every accepted entry is stored.

Test Plan:
- Reset with default parameters: hold rst 2 cycles, then release → out_valid_o=0, out_inst_o=32'h13, out_addr_o=0, in_ready_o=1, occ_o=0.
- Streaming: out_ready_i=1, send addr 0x8000_0000/+4/+8 back-to-back → appear on consecutive cycles one cycle later, occ_o=1 throughout.
- Skid fill:
  - stimulus: out_ready_i=0, send A then B
  - after B: occ_o=2, in_ready_o=0, outputs hold A
  - raise out_ready_i → A popped, next cycle shows B, in_ready_o=1
- Flush with full skid: occ_o=2, assert flush_i together with in_valid_i → next cycle occ_o=0, out_valid_o=0, out_inst_o=0x13; the flushed input never appears.
- Simultaneous pop+accept: occ_o=1, out_ready_i=1, in_valid_i=1 with C → next cycle M=C, occ_o=1, S empty.
- PIPE_DROP_ADDR_EN defined: send addr 0x7FFF_FFFC then 0x8000_0000 → only 0x8000_0000 emerges. With the macro undefined, both emerge.
